nx1_8255_hs: RTL

- Clocked, parametrised successor of the NX1 8255 PIA.
- Adds Intel mode 1 strobed handshake I/O on ports A and B, with interrupt outputs, input synchronisers and per-bit output enables.
- Mode 0 remains bit-compatible.
- Sits on the Z80-side I/O decode, driving the printer, keyboard/sub-CPU and joystick ports. The CPU bus is sampled synchronously to I_CLK.

---
 rtl/nx1_pio_pkg.sv | 35 +++
 rtl/nx1_pio_hs_chan.sv | 69 ++++++
 rtl/nx1_8255_hs.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nx1_pio_pkg.sv
// Shared definitions for the NX1 8255-compatible PIO with mode 1 handshake.
// Contents: register addresses, the control word loaded at reset, the port A
// mode encoding, and the port C bit positions used by each handshake role.
package nx1_pio_pkg;

  localparam logic [1:0] PIO_PA  = 2'd0;
  localparam logic [1:0] PIO_PB  = 2'd1;
  localparam logic [1:0] PIO_PC  = 2'd2;
  localparam logic [1:0] PIO_CTL = 2'd3;

  // All ports input, everything mode 0.
  localparam logic [7:0] CTL_RST = 8'h9B;

  typedef enum logic [1:0] {
    MODE_0 = 2'b00,
    MODE_1 = 2'b01
  } pa_mode_e;

  // Port C bit positions taken over by the handshake logic.
  localparam int PC_INTR_B = 0;
  localparam int PC_HS_B   = 1;  // IBF_B (input) / OBF_B_n (output)
  localparam int PC_STB_B  = 2;  // STB_B_n (input) / ACK_B_n (output)
  localparam int PC_INTR_A = 3;
  localparam int PC_STB_A  = 4;
  localparam int PC_IBF_A  = 5;
  localparam int PC_ACK_A  = 6;
  localparam int PC_OBF_A  = 7;

  // Port A mode field 1x decodes as mode 1; with the mode 1 hardware
  // removed every field decodes to mode 0.
  function automatic pa_mode_e decode_pa_mode(input logic [1:0] field, input logic en);
    return (en && (field != 2'b00)) ? MODE_1 : MODE_0;
  endfunction

endpackage

// File: rtl/nx1_pio_hs_chan.sv
// One mode 1 strobe/ack handshake channel.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               mode set / channel not in mode 1: drop IBF/OBF and INTR
//   is_out            1 = output handshake (OBF/ACK), 0 = input (IBF/STB)
//   stb, stb_last     synchronised STB_n/ACK_n and its value one cycle earlier
//   port_in           synchronised port byte, latched on STB_n falling
//   cpu_wr            CPU write pulse to this port
//   rd_start, rd_end  first cycle of a CPU read of this port / first cycle after
//   inte              interrupt enable bit from the port C latch
//   full              IBF (input) or OBF active (output, OBF_n = ~full)
//   intr              interrupt request, INTR flag gated by inte
//   data              latched input byte
module nx1_pio_hs_chan
  import nx1_pio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       is_out,
  input  logic       stb,
  input  logic       stb_last,
  input  logic [7:0] port_in,
  input  logic       cpu_wr,
  input  logic       rd_start,
  input  logic       rd_end,
  input  logic       inte,
  output logic       full,
  output logic       intr,
  output logic [7:0] data
);

  logic fall, rise, flag;

  assign fall = stb_last & ~stb;
  assign rise = ~stb_last & stb;

  // Statement order encodes priority: later assignments win, so strobe/ack
  // edges beat CPU clears, while a CPU write beats ACK falling for OBF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      flag <= 1'b0;
      data <= '0;
    end else if (clr) begin
      full <= 1'b0;
      flag <= 1'b0;
    end else if (is_out) begin
      if (fall) full <= 1'b0;
      if (cpu_wr) begin
        full <= 1'b1;
        flag <= 1'b0;
      end
      if (rise && !full && inte) flag <= 1'b1;
    end else begin
      if (rd_start) flag <= 1'b0;
      if (rd_end) full <= 1'b0;
      if (fall) begin
        full <= 1'b1;
        data <= port_in;
      end
      if (rise && full && inte) flag <= 1'b1;
    end
  end

  // Clearing INTE masks the request at once; the flag itself is kept.
  assign intr = flag & inte;

endmodule

// File: rtl/nx1_8255_hs.sv
// NX1 8255 PIA successor: mode 0 ports plus mode 1 strobed handshake on A/B.
// Ports:
//   I_CLK, I_RESET_N          clock, asynchronous active-low reset
//   I_A, I_CS, I_RD, I_WR     register select and bus strobes (sampled on I_CLK)
//   I_D, O_D                  write data, combinational read data
//   I_PA/I_PB/I_PC            port pins (synchronised internally)
//   O_PA/O_PB/O_PC            port output values
//   O_PA_OE/O_PB_OE/O_PC_OE   per-bit output enables, 1 = drive
//   O_INTR_A, O_INTR_B        interrupt requests
module nx1_8255_hs
  import nx1_pio_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_OUT     = 8'hFF,
  parameter int         MODE1_EN    = 1
) (
  input  logic       I_CLK,
  input  logic       I_RESET_N,
  input  logic [1:0] I_A,
  input  logic       I_CS,
  input  logic       I_RD,
  input  logic       I_WR,
  input  logic [7:0] I_D,
  output logic [7:0] O_D,
  input  logic [7:0] I_PA,
  input  logic [7:0] I_PB,
  input  logic [7:0] I_PC,
  output logic [7:0] O_PA,
  output logic [7:0] O_PB,
  output logic [7:0] O_PC,
  output logic [7:0] O_PA_OE,
  output logic [7:0] O_PB_OE,
  output logic [7:0] O_PC_OE,
  output logic       O_INTR_A,
  output logic       O_INTR_B
);

  localparam logic M1_EN = (MODE1_EN != 0);

  logic        wr_act, wr_q, wr_pulse;
  logic        rd_act, rd_q, rd_start, rd_end;
  logic [1:0]  rd_addr_q;
  logic        mode_set;
  logic [7:0]  pa_o, pb_o, pc_o;
  pa_mode_e    pa_mode;
  logic        pa_m1, pb_m1, pa_dir, pch_dir, pb_dir, pcl_dir;
  logic [23:0] sync_p [SYNC_STAGES];
  logic [7:0]  pa_s, pb_s, pc_s;
  logic        stb_a_last, ack_a_last, stb_b_last;
  logic        stb_a, stb_a_prev, inte_a, inte_b;
  logic        full_a, full_b, intr_a, intr_b;
  logic [7:0]  data_a, data_b;
  logic [7:0]  pc_drv, pc_oe, pc_rd;

  // Bus strobes act on their first cycle only; reads also act on the cycle
  // after they drop, against the address captured when they started.
  assign wr_act   = I_CS & I_WR;
  assign wr_pulse = wr_act & ~wr_q;
  assign rd_act   = I_CS & I_RD;
  assign rd_start = rd_act & ~rd_q;
  assign rd_end   = rd_q & ~rd_act;
  assign mode_set = wr_pulse && (I_A == PIO_CTL) && I_D[7];
  assign pa_m1    = (pa_mode == MODE_1);

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      rd_addr_q <= PIO_PA;
      pa_o      <= RST_OUT;
      pb_o      <= RST_OUT;
      pc_o      <= RST_OUT;
      pa_mode   <= decode_pa_mode(CTL_RST[6:5], M1_EN);
      pa_dir    <= CTL_RST[4];
      pch_dir   <= CTL_RST[3];
      pb_m1     <= M1_EN & CTL_RST[2];
      pb_dir    <= CTL_RST[1];
      pcl_dir   <= CTL_RST[0];
    end else begin
      wr_q <= wr_act;
      rd_q <= rd_act;
      if (rd_start) rd_addr_q <= I_A;
      if (wr_pulse) begin
        case (I_A)
          PIO_PA: pa_o <= I_D;
          PIO_PB: pb_o <= I_D;
          PIO_PC: pc_o <= I_D;
          default: begin
            if (I_D[7]) begin
              pa_mode <= decode_pa_mode(I_D[6:5], M1_EN);
              pa_dir  <= I_D[4];
              pch_dir <= I_D[3];
              pb_m1   <= M1_EN & I_D[2];
              pb_dir  <= I_D[1];
              pcl_dir <= I_D[0];
              pa_o    <= RST_OUT;
              pb_o    <= RST_OUT;
              pc_o    <= RST_OUT;
            end else begin
              pc_o[I_D[3:1]] <= I_D[0];
            end
          end
        endcase
      end
    end
  end

  // ---- pin synchronisers: stage 0 samples the pins ----
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= {I_PC, I_PB, I_PA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign pa_s = sync_p[SYNC_STAGES-1][7:0];
  assign pb_s = sync_p[SYNC_STAGES-1][15:8];
  assign pc_s = sync_p[SYNC_STAGES-1][23:16];

  // ---- edge-detect history, one flop per strobe pin position ----
  // Kept per pin so that switching port A direction cannot fake an edge.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      stb_a_last <= 1'b0;
      ack_a_last <= 1'b0;
      stb_b_last <= 1'b0;
    end else begin
      stb_a_last <= pc_s[PC_STB_A];
      ack_a_last <= pc_s[PC_ACK_A];
      stb_b_last <= pc_s[PC_STB_B];
    end
  end

  assign stb_a      = pa_dir ? pc_s[PC_STB_A] : pc_s[PC_ACK_A];
  assign stb_a_prev = pa_dir ? stb_a_last     : ack_a_last;
  assign inte_a     = pa_dir ? pc_o[PC_STB_A] : pc_o[PC_ACK_A];
  assign inte_b     = pc_o[PC_STB_B];

  nx1_pio_hs_chan u_chan_a (
    .clk      (I_CLK),
    .rst_n    (I_RESET_N),
    .clr      (mode_set | ~pa_m1),
    .is_out   (~pa_dir),
    .stb      (stb_a),
    .stb_last (stb_a_prev),
    .port_in  (pa_s),
    .cpu_wr   (wr_pulse && (I_A == PIO_PA)),
    .rd_start (rd_start && (I_A == PIO_PA)),
    .rd_end   (rd_end && (rd_addr_q == PIO_PA)),
    .inte     (inte_a),
    .full     (full_a),
    .intr     (intr_a),
    .data     (data_a)
  );

  nx1_pio_hs_chan u_chan_b (
    .clk      (I_CLK),
    .rst_n    (I_RESET_N),
    .clr      (mode_set | ~pb_m1),
    .is_out   (~pb_dir),
    .stb      (pc_s[PC_STB_B]),
    .stb_last (stb_b_last),
    .port_in  (pb_s),
    .cpu_wr   (wr_pulse && (I_A == PIO_PB)),
    .rd_start (rd_start && (I_A == PIO_PB)),
    .rd_end   (rd_end && (rd_addr_q == PIO_PB)),
    .inte     (inte_b),
    .full     (full_b),
    .intr     (intr_b),
    .data     (data_b)
  );

  // Port C: mode 0 nibble rules first, then handshake-owned bits override.
  // The STB/ACK position is an input on the pin but reads back as INTE.
  always_comb begin
    pc_drv = pc_o;
    pc_oe  = {{4{~pch_dir}}, {4{~pcl_dir}}};
    pc_rd  = {pch_dir ? pc_s[7:4] : pc_o[7:4], pcl_dir ? pc_s[3:0] : pc_o[3:0]};
    if (pa_m1) begin
      pc_drv[PC_INTR_A] = intr_a;
      pc_oe[PC_INTR_A]  = 1'b1;
      pc_rd[PC_INTR_A]  = intr_a;
      if (pa_dir) begin
        pc_drv[PC_IBF_A] = full_a;
        pc_oe[PC_IBF_A]  = 1'b1;
        pc_rd[PC_IBF_A]  = full_a;
        pc_oe[PC_STB_A]  = 1'b0;
        pc_rd[PC_STB_A]  = pc_o[PC_STB_A];
      end else begin
        pc_drv[PC_OBF_A] = ~full_a;
        pc_oe[PC_OBF_A]  = 1'b1;
        pc_rd[PC_OBF_A]  = ~full_a;
        pc_oe[PC_ACK_A]  = 1'b0;
        pc_rd[PC_ACK_A]  = pc_o[PC_ACK_A];
      end
    end
    if (pb_m1) begin
      pc_drv[PC_INTR_B] = intr_b;
      pc_oe[PC_INTR_B]  = 1'b1;
      pc_rd[PC_INTR_B]  = intr_b;
      pc_drv[PC_HS_B]   = pb_dir ? full_b : ~full_b;
      pc_oe[PC_HS_B]    = 1'b1;
      pc_rd[PC_HS_B]    = pb_dir ? full_b : ~full_b;
      pc_oe[PC_STB_B]   = 1'b0;
      pc_rd[PC_STB_B]   = pc_o[PC_STB_B];
    end
  end

  always_comb begin
    O_D = '0;
    case (I_A)
      PIO_PA:  O_D = (pa_m1 && pa_dir) ? data_a : (pa_dir ? pa_s : pa_o);
      PIO_PB:  O_D = (pb_m1 && pb_dir) ? data_b : (pb_dir ? pb_s : pb_o);
      PIO_PC:  O_D = pc_rd;
      default: O_D = {1'b1, pa_mode, pa_dir, pch_dir, pb_m1, pb_dir, pcl_dir};
    endcase
  end

  assign O_PA     = pa_o;
  assign O_PB     = pb_o;
  assign O_PC     = pc_drv;
  assign O_PA_OE  = {8{~pa_dir}};
  assign O_PB_OE  = {8{~pb_dir}};
  assign O_PC_OE  = pc_oe;
  assign O_INTR_A = intr_a;
  assign O_INTR_B = intr_b;

endmodule
